// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port.
// One request in flight at a time: accept, wait LATENCY cycles, then hold the
// response until the core takes it. A store to the tohost word latches a
// sticky done/pass result for simulation and board LEDs.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'hBC,
  parameter logic [31:0] PASS_VALUE  = 32'd25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        done,
  output logic        pass
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        init_q;
  logic        lat_write_q;
  logic [31:0] lat_addr_q;
  logic [31:0] lat_wdata_q;
  logic [3:0]  lat_be_q;
  logic [31:0] rdata_q;
  logic        error_q;
  logic        done_q;
  logic        pass_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_be;
  logic        cur_err;
  logic [AW-1:0] cur_idx;

  assign req_ready = (state_q == StIdle) && init_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;
  assign done      = done_q;
  assign pass      = pass_q;

  assign accept = req_valid && req_ready;

  // With zero latency the access commits on the accept edge, so the live
  // request fields are used; otherwise the latched copy is used.
  always_comb begin
    cur_write = lat_write_q;
    cur_addr  = lat_addr_q;
    cur_wdata = lat_wdata_q;
    cur_be    = lat_be_q;
    if (state_q == StIdle) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
    cur_err = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    cur_idx = cur_addr[AW+1:2];
    commit  = ((state_q == StIdle) && accept && (LATENCY == 0)) ||
              ((state_q == StWait) && (cnt_q == 4'd1));
  end

  // Next-state logic for the request/wait/response sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, request latch, response data and sticky tohost result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      init_q      <= 1'b0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 32'd0;
      lat_be_q    <= 4'd0;
      rdata_q     <= 32'd0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b1;
      if (accept) begin
        lat_write_q <= req_write;
        lat_addr_q  <= req_addr;
        lat_wdata_q <= req_wdata;
        lat_be_q    <= req_be;
      end
      if (commit) begin
        error_q <= cur_err;
        rdata_q <= (cur_err || cur_write) ? 32'd0 : mem[cur_idx];
        // First tohost store wins; the full word decides pass regardless of be.
        if (!cur_err && cur_write && (cur_addr == TOHOST_ADDR) && !done_q) begin
          done_q <= 1'b1;
          pass_q <= (cur_wdata == PASS_VALUE);
        end
      end
    end
  end

  // RAM byte writes; contents survive reset, but a reset edge blocks the commit.
  always_ff @(posedge clk) begin
    if (reset && commit && cur_write && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance (index 0) and a LATENCY=0
// instance (index 1) driven from a vector table plus hand-written sequences.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        rv  [2];
  logic        rr  [2];
  logic        rw  [2];
  logic [31:0] ra  [2];
  logic [31:0] wd  [2];
  logic [3:0]  be  [2];
  logic        sv  [2];
  logic        sr  [2];
  logic [31:0] rd  [2];
  logic        se  [2];
  logic        dn  [2];
  logic        ps  [2];

  dmem_responder #(.LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rr[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_wdata(wd[0]), .req_be(be[0]), .rsp_valid(sv[0]),
    .rsp_ready(sr[0]), .rsp_rdata(rd[0]), .rsp_error(se[0]), .done(dn[0]), .pass(ps[0])
  );

  dmem_responder #(.LATENCY(0)) u_dut_l0 (
    .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rr[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_wdata(wd[1]), .req_be(be[1]), .rsp_valid(sv[1]),
    .rsp_ready(sr[1]), .rsp_rdata(rd[1]), .rsp_error(se[1]), .done(dn[1]), .pass(ps[1])
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic pre_done, at_done, at_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request on instance d, check the response against the scoreboard,
  // optionally holding rsp_ready low for 'hold' cycles while offering a stray store.
  task automatic do_req(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wdat, input logic [3:0] b,
                        input logic [31:0] er, input logic ee, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    rv[d] = 1'b1; rw[d] = w; ra[d] = a; wd[d] = wdat; be[d] = b;
    n = 0;
    while (!rr[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rr[d]) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1 (inst %0d)", d);
      rv[d] = 1'b0;
      return;
    end
    e.rdata = er; e.err = ee; e.lat = (d == 0) ? 3 : 1;
    sb_q.push_back(e);
    pre_done = dn[d];
    @(posedge clk);
    #1;
    // Scramble request fields after accept; they must be ignored.
    rv[d] = 1'b0; rw[d] = ~w; ra[d] = 32'hFFFF_FFFF; wd[d] = ~wdat; be[d] = ~b;
    n = 1;
    @(negedge clk);
    while (!sv[d] && n < 40) begin
      pre_done = dn[d];
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    if (!sv[d]) begin
      checks++; errors++;
      $display("FAIL rsp_valid_timeout: got 0 expected 1 (inst %0d)", d);
      return;
    end
    check("latency", 32'(n), 32'(e.lat));
    check("rsp_rdata", rd[d], e.rdata);
    check("rsp_error", {31'd0, se[d]}, {31'd0, e.err});
    at_done = dn[d];
    at_pass = ps[d];
    if (hold > 0) begin
      rv[d] = 1'b1; rw[d] = 1'b1; ra[d] = 32'h40; wd[d] = 32'h99; be[d] = 4'hF;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_stable", {31'd0, (sv[d] === 1'b1) && (rd[d] === e.rdata) &&
              (rr[d] === 1'b0)}, 32'd1);
      end
      rv[d] = 1'b0;
    end
    sr[d] = 1'b1;
    @(posedge clk);
    #1;
    sr[d] = 1'b0;
    @(negedge clk);
    check("rsp_drop", {31'd0, sv[d]}, 32'd0);
    check("ready_after", {31'd0, rr[d]}, 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs = '{
      '{1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0,         1'b0},
      '{1'b0, 32'h40, 32'h0,         4'h0, 32'h1234_5678, 1'b0},
      '{1'b1, 32'h00, 32'h0,         4'hF, 32'h0,         1'b0},
      '{1'b1, 32'h00, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0},
      '{1'b0, 32'h00, 32'h0,         4'h0, 32'h00BB_00DD, 1'b0},
      '{1'b0, 32'h41, 32'h0,         4'h0, 32'h0,         1'b1},
      '{1'b0, 32'h100, 32'h0,        4'h0, 32'h0,         1'b1},
      '{1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0,        1'b1},
      '{1'b1, 32'h42, 32'h5555_5555, 4'hF, 32'h0,         1'b1},
      '{1'b0, 32'h40, 32'h0,         4'h0, 32'h1234_5678, 1'b0},
      '{1'b0, 32'h00, 32'h0,         4'h0, 32'h00BB_00DD, 1'b0},
      '{1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0},
      '{1'b0, 32'h40, 32'h0,         4'h0, 32'h1234_5678, 1'b0},
      '{1'b1, 32'hFC, 32'h1122_3344, 4'hF, 32'h0,         1'b0},
      '{1'b0, 32'hFC, 32'h0,         4'h0, 32'h1122_3344, 1'b0},
      '{1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 32'h0,         1'b0}
    };
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = 32'd0; wd[d] = 32'd0;
      be[d] = 4'd0; sr[d] = 1'b0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", {31'd0, rr[d]}, 32'd0);
      check("rst_rsp_valid", {31'd0, sv[d]}, 32'd0);
      check("rst_rsp_rdata", rd[d], 32'd0);
      check("rst_rsp_error", {31'd0, se[d]}, 32'd0);
      check("rst_done_pass", {30'd0, dn[d], ps[d]}, 32'd0);
    end
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst0", {31'd0, rr[0]}, 32'd1);
    check("ready_after_rst1", {31'd0, rr[1]}, 32'd1);

    // Table vectors on the LATENCY=2 instance.
    foreach (vecs[i])
      do_req(0, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_rdata, vecs[i].exp_err, 0);

    // Zero-latency instance basics.
    do_req(1, 1'b1, 32'h10, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0, 0);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h5A5A_5A5A, 1'b0, 0);

    // tohost pass, then a later store must not change the result.
    check("done_before_tohost", {31'd0, dn[0]}, 32'd0);
    do_req(0, 1'b1, 32'hBC, 32'd25, 4'h1, 32'h0, 1'b0, 0);
    check("done_pre_commit", {31'd0, pre_done}, 32'd0);
    check("done_pass_at_commit", {30'd0, at_done, at_pass}, 32'd3);
    do_req(0, 1'b1, 32'hBC, 32'd7, 4'hF, 32'h0, 1'b0, 0);
    check("done_pass_sticky", {30'd0, at_done, at_pass}, 32'd3);
    do_req(0, 1'b0, 32'hBC, 32'h0, 4'h0, 32'd7, 1'b0, 0);

    // tohost fail on the zero-latency instance; first store wins.
    do_req(1, 1'b1, 32'hBC, 32'd26, 4'hF, 32'h0, 1'b0, 0);
    check("fail_at_commit", {30'd0, at_done, at_pass}, 32'd2);
    do_req(1, 1'b1, 32'hBC, 32'd25, 4'hF, 32'h0, 1'b0, 0);
    check("fail_sticky", {30'd0, dn[1], ps[1]}, 32'd2);

    // Backpressure: response held 5 cycles while a stray store is offered.
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 5);
    do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0);

    // Reset on the would-be commit edge of a LATENCY=2 store.
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h10; wd[0] = 32'hFF; be[0] = 4'hF;
    check("ready_for_abort", {31'd0, rr[0]}, 32'd1);
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_rsp_valid", {31'd0, sv[0]}, 32'd0);
    check("abort_req_ready", {31'd0, rr[0]}, 32'd0);
    check("abort_done_pass", {30'd0, dn[0], ps[0]}, 32'd0);
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_ready_back", {31'd0, rr[0]}, 32'd1);
    repeat (4) @(negedge clk);
    check("abort_no_rsp", {31'd0, sv[0]}, 32'd0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, 0);

    // Reset coinciding with accept on the LATENCY=0 instance.
    @(negedge clk);
    rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 32'h10; wd[1] = 32'hFF; be[1] = 4'hF;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;
    rv[1] = 1'b0;
    @(negedge clk);
    check("abort0_rsp_valid", {31'd0, sv[1]}, 32'd0);
    check("abort0_done", {31'd0, dn[1]}, 32'd0);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort0_ready_back", {31'd0, rr[1]}, 32'd1);
    do_req(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h5A5A_5A5A, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
